// File: rtl/terminal_cursor_ctrl.sv
// Terminal cursor controller: turns a UART byte stream into character RAM writes,
// tracks the cursor and blanks a line or the whole screen with 0x20 writes.
module terminal_cursor_ctrl #(
   parameter int WIDTH_CHARS  = 80,
   parameter int HEIGHT_CHARS = 30
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [7:0]  RxData_i,
   input  logic        RxValid_i,
   output logic [11:0] WrAddr_o,
   output logic [7:0]  WrData_o,
   output logic        WrEnable_o,
   output logic [6:0]  CursorX_o,
   output logic [4:0]  CursorY_o,
   output logic        Busy_o,
   output logic        Overrun_o
);

   typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_SCREEN} state_t;

   localparam logic [6:0]  X_LAST     = 7'(WIDTH_CHARS - 1);
   localparam logic [4:0]  Y_LAST     = 5'(HEIGHT_CHARS - 1);
   localparam logic [11:0] LINE_LEN   = 12'(WIDTH_CHARS);
   localparam logic [11:0] SCREEN_LEN = 12'(WIDTH_CHARS * HEIGHT_CHARS);
   localparam logic [7:0]  BLANK      = 8'h20;

   state_t      r_state;
   logic [6:0]  r_x;
   logic [4:0]  r_y;
   logic [11:0] r_lineBase;
   logic [11:0] r_clrAddr;
   logic [11:0] r_clrCnt;
   logic [11:0] r_wrAddr;
   logic [7:0]  r_wrData;
   logic        r_wrEn;
   logic        r_busy;
   logic        r_overrun;

   logic        w_lastRow;
   logic [4:0]  w_nextY;
   logic [11:0] w_nextBase;
   logic [11:0] w_glyphAddr;

   // r_lineBase always holds r_y*WIDTH_CHARS, stepped by WIDTH_CHARS on each row advance.
   assign w_lastRow   = (r_y == Y_LAST);
   assign w_nextY     = w_lastRow ? 5'd0 : r_y + 5'd1;
   assign w_nextBase  = w_lastRow ? 12'd0 : r_lineBase + LINE_LEN;
   assign w_glyphAddr = r_lineBase + {5'd0, r_x};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state    <= CLEAR_SCREEN;
         r_x        <= '0;
         r_y        <= '0;
         r_lineBase <= '0;
         r_clrAddr  <= '0;
         r_clrCnt   <= '0;
         r_wrAddr   <= '0;
         r_wrData   <= BLANK;
         r_wrEn     <= 1'b0;
         r_busy     <= 1'b1;
         r_overrun  <= 1'b0;
      end else begin
         r_wrEn    <= 1'b0;
         r_overrun <= 1'b0;
         case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (RxValid_i) begin
                  case (RxData_i)
                     8'h08: begin
                        if (r_x != 7'd0) r_x <= r_x - 7'd1;
                     end
                     8'h0D: begin
                        r_x <= '0;
                     end
                     8'h0A: begin
                        // The first blank of the new row goes out with the accepting edge.
                        r_y        <= w_nextY;
                        r_lineBase <= w_nextBase;
                        r_wrEn     <= 1'b1;
                        r_wrAddr   <= w_nextBase;
                        r_wrData   <= BLANK;
                        r_clrAddr  <= w_nextBase + 12'd1;
                        r_clrCnt   <= 12'd1;
                        r_busy     <= 1'b1;
                        r_state    <= CLEAR_LINE;
                     end
                     8'h0C: begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= 12'd0;
                        r_wrData <= BLANK;
                        r_clrCnt <= 12'd1;
                        r_busy   <= 1'b1;
                        r_state  <= CLEAR_SCREEN;
                     end
                     default: begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= w_glyphAddr;
                        r_wrData <= RxData_i;
                        if (r_x == X_LAST) begin
                           r_x        <= '0;
                           r_y        <= w_nextY;
                           r_lineBase <= w_nextBase;
                           r_clrAddr  <= w_nextBase;
                           r_clrCnt   <= 12'd0;
                           r_busy     <= 1'b1;
                           r_state    <= CLEAR_LINE;
                        end else begin
                           r_x <= r_x + 7'd1;
                        end
                     end
                  endcase
               end
            end
            CLEAR_LINE: begin
               r_overrun <= RxValid_i;
               if (r_clrCnt == LINE_LEN) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_wrEn    <= 1'b1;
                  r_wrAddr  <= r_clrAddr;
                  r_wrData  <= BLANK;
                  r_clrAddr <= r_clrAddr + 12'd1;
                  r_clrCnt  <= r_clrCnt + 12'd1;
                  r_busy    <= 1'b1;
               end
            end
            CLEAR_SCREEN: begin
               r_overrun <= RxValid_i;
               if (r_clrCnt == SCREEN_LEN) begin
                  r_x        <= '0;
                  r_y        <= '0;
                  r_lineBase <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_wrEn   <= 1'b1;
                  r_wrAddr <= r_clrCnt;
                  r_wrData <= BLANK;
                  r_clrCnt <= r_clrCnt + 12'd1;
                  r_busy   <= 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign WrAddr_o   = r_wrAddr;
   assign WrData_o   = r_wrData;
   assign WrEnable_o = r_wrEn;
   assign CursorX_o  = r_x;
   assign CursorY_o  = r_y;
   assign Busy_o     = r_busy;
   assign Overrun_o  = r_overrun;

endmodule

// File: tb/tb_terminal_cursor_ctrl.sv
// Directed bench for terminal_cursor_ctrl: reset clear, glyph writes, wrap,
// control codes, overrun during a clear and reset abort of a screen clear.
module tb_terminal_cursor_ctrl;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  RxData = 8'h00;
   logic        RxValid = 1'b0;
   logic [11:0] WrAddr;
   logic [7:0]  WrData;
   logic        WrEnable;
   logic [6:0]  CursorX;
   logic [4:0]  CursorY;
   logic        Busy;
   logic        Overrun;

   int compared = 0;
   int mismatched = 0;

   always #5 Clock = ~Clock;

   terminal_cursor_ctrl #(
      .WIDTH_CHARS (80),
      .HEIGHT_CHARS(30)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .RxData_i  (RxData),
      .RxValid_i (RxValid),
      .WrAddr_o  (WrAddr),
      .WrData_o  (WrData),
      .WrEnable_o(WrEnable),
      .CursorX_o (CursorX),
      .CursorY_o (CursorY),
      .Busy_o    (Busy),
      .Overrun_o (Overrun)
   );

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      RxData  = b;
      RxValid = 1'b1;
      tick();
      RxValid = 1'b0;
   endtask

   task automatic checkCursor(input string tag, input int x, input int y);
      checkOutput({tag, "_x"}, 32'(CursorX), 32'(x));
      checkOutput({tag, "_y"}, 32'(CursorY), 32'(y));
   endtask

   task automatic checkClear(input int startAddr, input int len);
      for (int i = 0; i < len; i++) begin
         tick();
         checkOutput("clr_en", 32'(WrEnable), 32'd1);
         checkOutput("clr_addr", 32'(WrAddr), 32'(startAddr + i));
         checkOutput("clr_data", 32'(WrData), 32'h20);
         checkOutput("clr_busy", 32'(Busy), 32'd1);
      end
      tick();
      checkOutput("clr_done_busy", 32'(Busy), 32'd0);
      checkOutput("clr_done_en", 32'(WrEnable), 32'd0);
   endtask

   task automatic lineFeedNoCheck();
      applyStimulus(8'h0A);
      repeat (80) tick();
   endtask

   initial begin
      // Reset held: outputs at their reset values
      tick();
      tick();
      checkOutput("rst_en", 32'(WrEnable), 32'd0);
      checkOutput("rst_addr", 32'(WrAddr), 32'd0);
      checkOutput("rst_data", 32'(WrData), 32'h20);
      checkOutput("rst_busy", 32'(Busy), 32'd1);
      checkOutput("rst_ovr", 32'(Overrun), 32'd0);
      checkCursor("rst", 0, 0);

      // Release: full screen clear 0..2399
      Reset = 1'b0;
      checkClear(0, 2400);
      checkCursor("pwrup", 0, 0);

      // Single glyph at (0,0)
      applyStimulus(8'h41);
      checkOutput("g_en", 32'(WrEnable), 32'd1);
      checkOutput("g_addr", 32'(WrAddr), 32'd0);
      checkOutput("g_data", 32'(WrData), 32'h41);
      checkOutput("g_busy", 32'(Busy), 32'd0);
      checkCursor("g", 1, 0);
      tick();
      checkOutput("g_idle_en", 32'(WrEnable), 32'd0);

      // CR back to column 0, then a full row of glyphs with wrap
      applyStimulus(8'h0D);
      checkOutput("cr_en", 32'(WrEnable), 32'd0);
      checkCursor("cr", 0, 0);
      for (int i = 0; i < 80; i++) begin
         logic [7:0] g;
         g = 8'(8'h41 + (i % 26));
         applyStimulus(g);
         checkOutput("row_en", 32'(WrEnable), 32'd1);
         checkOutput("row_addr", 32'(WrAddr), 32'(i));
         checkOutput("row_data", 32'(WrData), 32'(g));
         if (i < 79) begin
            checkCursor("row", i + 1, 0);
            checkOutput("row_busy", 32'(Busy), 32'd0);
         end else begin
            checkCursor("wrap", 0, 1);
            checkOutput("wrap_busy", 32'(Busy), 32'd1);
         end
      end
      checkClear(80, 80);

      // LF to row 2, then move to (5,2)
      applyStimulus(8'h0A);
      checkOutput("lf1_en", 32'(WrEnable), 32'd1);
      checkOutput("lf1_addr", 32'(WrAddr), 32'd160);
      checkOutput("lf1_busy", 32'(Busy), 32'd1);
      checkCursor("lf1", 0, 2);
      checkClear(161, 79);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'h30);
         checkOutput("p_addr", 32'(WrAddr), 32'(160 + i));
      end
      checkCursor("at52", 5, 2);

      // BS, CR, BS at column 0, LF
      applyStimulus(8'h08);
      checkOutput("bs_en", 32'(WrEnable), 32'd0);
      checkCursor("bs", 4, 2);
      applyStimulus(8'h0D);
      checkCursor("cr2", 0, 2);
      applyStimulus(8'h08);
      checkOutput("bs0_en", 32'(WrEnable), 32'd0);
      checkCursor("bs0", 0, 2);
      applyStimulus(8'h0A);
      checkOutput("lf2_en", 32'(WrEnable), 32'd1);
      checkOutput("lf2_addr", 32'(WrAddr), 32'd240);
      checkOutput("lf2_data", 32'(WrData), 32'h20);
      checkCursor("lf2", 0, 3);
      checkClear(241, 79);

      // Walk to (79,29)
      for (int i = 0; i < 26; i++) lineFeedNoCheck();
      checkCursor("row29", 0, 29);
      checkOutput("row29_busy", 32'(Busy), 32'd0);
      for (int i = 0; i < 79; i++) applyStimulus(8'h2E);
      checkCursor("at7929", 79, 29);

      // Glyph at last cell wraps to (0,0) and clears row 0; byte strobed mid-clear is dropped
      applyStimulus(8'h5A);
      checkOutput("last_en", 32'(WrEnable), 32'd1);
      checkOutput("last_addr", 32'(WrAddr), 32'd2399);
      checkOutput("last_data", 32'(WrData), 32'h5A);
      checkOutput("last_busy", 32'(Busy), 32'd1);
      checkCursor("last", 0, 0);
      tick();
      checkOutput("lc0_addr", 32'(WrAddr), 32'd0);
      tick();
      checkOutput("lc1_addr", 32'(WrAddr), 32'd1);
      applyStimulus(8'h42);
      checkOutput("ovr_pulse", 32'(Overrun), 32'd1);
      checkOutput("ovr_addr", 32'(WrAddr), 32'd2);
      checkOutput("ovr_data", 32'(WrData), 32'h20);
      checkCursor("ovr", 0, 0);
      tick();
      checkOutput("ovr_end", 32'(Overrun), 32'd0);
      checkOutput("ovr_addr3", 32'(WrAddr), 32'd3);
      checkClear(4, 76);
      checkCursor("ovr_done", 0, 0);

      // Move to (10,7), FF, then reset at the 50th clear write
      for (int i = 0; i < 7; i++) lineFeedNoCheck();
      for (int i = 0; i < 10; i++) applyStimulus(8'h23);
      checkCursor("at107", 10, 7);
      applyStimulus(8'h0C);
      checkOutput("ff_en", 32'(WrEnable), 32'd1);
      checkOutput("ff_addr", 32'(WrAddr), 32'd0);
      checkOutput("ff_busy", 32'(Busy), 32'd1);
      checkCursor("ff", 10, 7);
      for (int i = 1; i < 50; i++) begin
         tick();
         checkOutput("ff_seq_addr", 32'(WrAddr), 32'(i));
      end
      Reset = 1'b1;
      #2;
      checkOutput("abort_en", 32'(WrEnable), 32'd0);
      checkOutput("abort_addr", 32'(WrAddr), 32'd0);
      checkOutput("abort_busy", 32'(Busy), 32'd1);
      checkCursor("abort", 0, 0);
      tick();
      Reset = 1'b0;
      checkClear(0, 2400);
      checkCursor("restart_done", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/terminal_cursor_ctrl.md
TERMINAL_CURSOR_CTRL -- requirements
Module: terminal_cursor_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH_CHARS, default 80: characters per text row.
REQ-002 The block SHALL have parameter HEIGHT_CHARS, default 30: text rows per screen.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port RxData_i, input, 8 bits: byte received from the UART receiver.
REQ-006 The block SHALL have port RxValid_i, input, 1 bit: one-cycle strobe qualifying RxData_i.
REQ-007 The block SHALL have port WrAddr_o, output, 12 bits: character RAM write address, Y*WIDTH_CHARS+X.
REQ-008 The block SHALL have port WrData_o, output, 8 bits: character code to write.
REQ-009 The block SHALL have port WrEnable_o, output, 1 bit: character RAM write strobe, one write per cycle.
REQ-010 The block SHALL have port CursorX_o, output, 7 bits: cursor column, 0..WIDTH_CHARS-1.
REQ-011 The block SHALL have port CursorY_o, output, 5 bits: cursor row, 0..HEIGHT_CHARS-1.
REQ-012 The block SHALL have port Busy_o, output, 1 bit: high while a clear sequence owns the write port.
REQ-013 The block SHALL have port Overrun_o, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have three states: IDLE, CLEAR_LINE and CLEAR_SCREEN.
REQ-016 Busy_o SHALL equal 1 exactly when the state is CLEAR_LINE or CLEAR_SCREEN.
REQ-017 A byte SHALL be accepted only in IDLE with RxValid_i=1.
REQ-018 RxValid_i=1 while Busy_o=1 SHALL produce no write, no cursor change, and Overrun_o=1 in the next cycle.
REQ-019 Control codes SHALL be 0x08 BS, 0x0A LF, 0x0C FF and 0x0D CR; every other byte value 0x00..0xFF SHALL be a glyph.
REQ-020 Glyph accepted in cycle N SHALL give, in cycle N+1: WrEnable_o=1, WrAddr_o=address of the pre-advance cursor, WrData_o=byte, and the advanced cursor outputs.
REQ-021 Glyph cursor advance: X+1; if X=WIDTH_CHARS-1, then X=0 and the row advances.
REQ-022 Row advance: Y+1; if Y=HEIGHT_CHARS-1, then Y=0 (wrap, no scroll); every row advance SHALL enter CLEAR_LINE for the new row.
REQ-023 BS: if X>0, then X-1; if X=0, no change; no write.
REQ-024 CR: X=0; no write.
REQ-025 LF: row advance per REQ-022; X unchanged; no glyph write.
REQ-026 FF: enter CLEAR_SCREEN.
REQ-027 CLEAR_LINE SHALL write 0x20 to Y*WIDTH_CHARS .. Y*WIDTH_CHARS+WIDTH_CHARS-1, ascending, one per cycle, for WIDTH_CHARS consecutive cycles, then return to IDLE.
REQ-028 CLEAR_SCREEN SHALL write 0x20 to 0 .. WIDTH_CHARS*HEIGHT_CHARS-1, ascending, one per cycle, then set cursor (0,0) and return to IDLE.
REQ-029 In both clear states, WrEnable_o=1 and Busy_o=1 in the same cycles; Busy_o SHALL fall in the cycle after the last clear write.
REQ-030 The first clear write SHALL appear in the cycle after the accepting edge; a glyph causing a wrap SHALL be written in that cycle and the clear line SHALL follow immediately.
REQ-031 WrEnable_o SHALL be 0 in every cycle without a write.
REQ-032 WrAddr_o SHALL never exceed WIDTH_CHARS*HEIGHT_CHARS-1 (2399 by default).
REQ-033 The implementation SHALL NOT use a multiplier; the line base SHALL be tracked incrementally.

Reset
REQ-034 While Reset=1: WrEnable_o=0, WrAddr_o=0, WrData_o=0x20, CursorX_o=0, CursorY_o=0, Overrun_o=0, Busy_o=1, state CLEAR_SCREEN, clear counter 0.
REQ-035 After Reset falls, CLEAR_SCREEN SHALL start at address 0 on the first rising edge.
REQ-036 Reset asserted mid-sequence SHALL abort it; the full screen clear SHALL restart from address 0 after release.

Verification
REQ-037 Release Reset -> 2400 writes of 0x20 at addresses 0..2399 on consecutive cycles; then Busy_o=0 and cursor (0,0).
REQ-038 Idle at (0,0), send 0x41 -> next cycle WrEnable_o=1, WrAddr_o=0, WrData_o=0x41; cursor (1,0).
REQ-039 Send 80 glyphs from (0,0) -> last glyph written at address 79; cursor (0,1); 80 writes of 0x20 at addresses 80..159 with Busy_o high; then Busy_o=0.
REQ-040 From (5,2): BS -> (4,2); CR -> (0,2); BS -> (0,2); LF -> (0,3) plus clear of addresses 240..319.
REQ-041 Glyph 0x5A at (79,29) -> write at address 2399; cursor (0,0); clear of addresses 0..79; a byte strobed during that clear -> no write, Overrun_o pulses, cursor stays (0,0).
REQ-042 Send FF at (10,7), then pulse Reset at the 50th clear write -> the clear restarts at address 0 and completes all 2400 writes; cursor (0,0).
